// File: rtl/mips_dmem.sv
// mips_dmem: word RAM plus MMIO page (console TX FIFO, status, scratch, optional cycle counter).
// Latency: reads combinational, writes commit at the rising edge; FIFO drains via con_valid/con_ready; full drops + sets overflow.
// Optional feature macro: MIPS_DMEM_CYCLE_CNT_EN (free-running CYCLE counter at 0x8000_0008).
module mips_dmem #(
    parameter int DATA_MEM_WIDTH = 32,
    parameter int RAM_DEPTH      = 256,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      memwrite,
    input  logic [DATA_MEM_WIDTH-1:0] memaddr,
    input  logic [DATA_MEM_WIDTH-1:0] writedata,
    output logic [DATA_MEM_WIDTH-1:0] readdata,
    output logic                      con_valid,
    output logic [7:0]                con_data,
    input  logic                      con_ready
);
    localparam int W  = DATA_MEM_WIDTH;
    localparam int AW = $clog2(RAM_DEPTH);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        REG_CON_TX  = 2'd0,
        REG_STATUS  = 2'd1,
        REG_CYCLE   = 2'd2,
        REG_SCRATCH = 2'd3
    } mmio_reg_t;

    logic [W-1:0]    ram [RAM_DEPTH];
    logic [AW-1:0]   ram_idx;
    logic            ram_sel;
    logic            mmio_hit;
    mmio_reg_t       reg_sel;

    logic [7:0]      fifo_mem [FIFO_DEPTH];
    logic [PW:0]     wr_ptr;
    logic [PW:0]     rd_ptr;
    logic [PW:0]     fifo_occ;
    logic            fifo_empty;
    logic            fifo_full;
    logic            push_req;
    logic            push;
    logic            pop;
    logic            overflow;
    logic [W-1:0]    scratch;
    logic [W-1:0]    cycle_cnt;
    logic            unused_addr;

    assign ram_sel     = ~memaddr[W-1];
    assign ram_idx     = memaddr[AW+1:2];
    assign mmio_hit    = memaddr[W-1] & ~|memaddr[W-2:4];
    assign reg_sel     = mmio_reg_t'(memaddr[3:2]);
    assign unused_addr = ^memaddr[1:0];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign fifo_occ   = wr_ptr - rd_ptr;
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

    assign pop      = ~fifo_empty & con_ready;
    assign push_req = memwrite & mmio_hit & (reg_sel == REG_CON_TX);
    assign push     = push_req & (~fifo_full | pop);

    assign con_valid = ~fifo_empty;
    assign con_data  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk) begin
        if (memwrite && ram_sel) begin
            ram[ram_idx] <= writedata;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[PW-1:0]] <= writedata[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
            scratch  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_req && !push) begin
                overflow <= 1'b1;
            end else if (memwrite && mmio_hit && reg_sel == REG_STATUS && writedata[2]) begin
                overflow <= 1'b0;
            end
            if (memwrite && mmio_hit && reg_sel == REG_SCRATCH) begin
                scratch <= writedata;
            end
        end
    end

`ifdef MIPS_DMEM_CYCLE_CNT_EN
    // A write to CYCLE wins over the increment on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt <= '0;
        end else if (memwrite && mmio_hit && reg_sel == REG_CYCLE) begin
            cycle_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 1'b1;
        end
    end
`else
    assign cycle_cnt = '0;
`endif

    always_comb begin
        readdata = '0;
        if (ram_sel) begin
            readdata = ram[ram_idx];
        end else if (mmio_hit) begin
            case (reg_sel)
                REG_CON_TX:  readdata = {{(W-PW-1){1'b0}}, fifo_occ};
                REG_STATUS:  readdata = {{(W-3){1'b0}}, overflow, fifo_empty, fifo_full};
                REG_CYCLE:   readdata = cycle_cnt;
                REG_SCRATCH: readdata = scratch;
                default:     readdata = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_dmem.sv
// Bench for mips_dmem: directed vector table, hand sequences for reset/counter, then random traffic vs. a queue-based model.
module tb_mips_dmem;
    localparam logic [31:0] CON  = 32'h8000_0000;
    localparam logic [31:0] STAT = 32'h8000_0004;
    localparam logic [31:0] CYC  = 32'h8000_0008;
    localparam logic [31:0] SCR  = 32'h8000_000C;
    localparam int FDEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        memwrite;
    logic [31:0] memaddr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        con_valid;
    logic [7:0]  con_data;
    logic        con_ready;

    int n_cmp = 0;
    int n_err = 0;

    mips_dmem #(.DATA_MEM_WIDTH(32), .RAM_DEPTH(256), .FIFO_DEPTH(FDEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .memwrite(memwrite), .memaddr(memaddr),
        .writedata(writedata), .readdata(readdata), .con_valid(con_valid),
        .con_data(con_data), .con_ready(con_ready)
    );

    always #5 clk = ~clk;

    // Reference model: behaviour stated in words, kept as arrays and a byte queue.
    logic [31:0] ram_m [256];
    bit          ram_v [256];
    logic [7:0]  q [$];
    bit          ovf_m;
    logic [31:0] scr_m;
    logic [31:0] cyc_m;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        rdy;
        logic        chk;
        logic [31:0] exp_rd;
        logic        exp_cv;
        logic [7:0]  exp_cd;
    } vec_t;
    vec_t tbl [34];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a, output bit known);
        known = 1'b1;
        if (!a[31]) begin
            known = ram_v[a[9:2]];
            return ram_m[a[9:2]];
        end
        if (a[30:4] != 0) return 32'h0;
        case (a[3:2])
            2'd0: return 32'(q.size());
            2'd1: return {29'b0, ovf_m, q.size() == 0, q.size() == FDEPTH};
`ifdef MIPS_DMEM_CYCLE_CNT_EN
            2'd2: return cyc_m;
`else
            2'd2: return 32'h0;
`endif
            default: return scr_m;
        endcase
    endfunction

    task automatic model_reset();
        q.delete();
        ovf_m = 1'b0;
        scr_m = 32'h0;
        cyc_m = 32'h0;
    endtask

    task automatic model_commit();
        bit full_before;
        bit popped;
        bit mmio;
        full_before = (q.size() == FDEPTH);
        popped      = (q.size() > 0) && con_ready;
        mmio        = memaddr[31] && (memaddr[30:4] == 0);
        if (popped) void'(q.pop_front());
        if (memwrite && !memaddr[31]) begin
            ram_m[memaddr[9:2]] = writedata;
            ram_v[memaddr[9:2]] = 1'b1;
        end
        if (memwrite && mmio && memaddr[3:2] == 2'd0) begin
            if (!full_before || popped) q.push_back(writedata[7:0]);
            else ovf_m = 1'b1;
        end
        if (memwrite && mmio && memaddr[3:2] == 2'd1 && writedata[2]) ovf_m = 1'b0;
        if (memwrite && mmio && memaddr[3:2] == 2'd3) scr_m = writedata;
        if (memwrite && mmio && memaddr[3:2] == 2'd2) cyc_m = 32'h0;
        else cyc_m = cyc_m + 32'h1;
    endtask

    task automatic check_model(input string tag);
        bit known;
        logic [31:0] exp;
        exp = model_read(memaddr, known);
        if (known) check({tag, ".readdata"}, readdata, exp);
        check({tag, ".con_valid"}, {31'b0, con_valid}, {31'b0, q.size() > 0});
        check({tag, ".con_data"}, {24'b0, con_data}, {24'b0, (q.size() > 0) ? q[0] : 8'h00});
    endtask

    // Called just after a rising edge: drive, check before the next edge, then commit the model.
    task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic rdy);
        memwrite  = we;
        memaddr   = a;
        writedata = wd;
        con_ready = rdy;
        @(negedge clk);
    endtask

    task automatic commit();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic step(input string tag, input logic we, input logic [31:0] a,
                        input logic [31:0] wd, input logic rdy);
        drive(we, a, wd, rdy);
        check_model(tag);
        commit();
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] wd;
        int          pick;

        tbl[0]  = '{1, 32'h10,  32'h1111_1111, 0, 0, 32'h0,         0, 8'h00};
        tbl[1]  = '{1, 32'h10,  32'hDEAD_BEEF, 0, 1, 32'h1111_1111, 0, 8'h00};
        tbl[2]  = '{0, 32'h10,  32'h0,         0, 1, 32'hDEAD_BEEF, 0, 8'h00};
        tbl[3]  = '{0, 32'h410, 32'h0,         0, 1, 32'hDEAD_BEEF, 0, 8'h00};
        tbl[4]  = '{0, STAT,    32'h0,         0, 1, 32'h2,         0, 8'h00};
        tbl[5]  = '{1, CON,     32'h41,        0, 1, 32'h0,         0, 8'h00};
        tbl[6]  = '{1, CON,     32'h42,        0, 1, 32'h1,         1, 8'h41};
        tbl[7]  = '{1, CON,     32'h43,        0, 1, 32'h2,         1, 8'h41};
        tbl[8]  = '{1, CON,     32'h44,        0, 1, 32'h3,         1, 8'h41};
        tbl[9]  = '{0, STAT,    32'h0,         0, 1, 32'h1,         1, 8'h41};
        tbl[10] = '{0, CON,     32'h0,         0, 1, 32'h4,         1, 8'h41};
        tbl[11] = '{1, CON,     32'h45,        0, 1, 32'h4,         1, 8'h41};
        tbl[12] = '{0, STAT,    32'h0,         0, 1, 32'h5,         1, 8'h41};
        tbl[13] = '{0, STAT,    32'h0,         1, 1, 32'h5,         1, 8'h41};
        tbl[14] = '{0, STAT,    32'h0,         1, 1, 32'h4,         1, 8'h42};
        tbl[15] = '{0, STAT,    32'h0,         1, 1, 32'h4,         1, 8'h43};
        tbl[16] = '{0, STAT,    32'h0,         1, 1, 32'h4,         1, 8'h44};
        tbl[17] = '{0, STAT,    32'h0,         0, 1, 32'h6,         0, 8'h00};
        tbl[18] = '{1, STAT,    32'h4,         0, 1, 32'h6,         0, 8'h00};
        tbl[19] = '{0, STAT,    32'h0,         0, 1, 32'h2,         0, 8'h00};
        tbl[20] = '{1, CON,     32'h61,        0, 1, 32'h0,         0, 8'h00};
        tbl[21] = '{1, CON,     32'h62,        0, 1, 32'h1,         1, 8'h61};
        tbl[22] = '{1, CON,     32'h63,        0, 1, 32'h2,         1, 8'h61};
        tbl[23] = '{1, CON,     32'h64,        0, 1, 32'h3,         1, 8'h61};
        tbl[24] = '{1, CON,     32'h55,        1, 1, 32'h4,         1, 8'h61};
        tbl[25] = '{0, STAT,    32'h0,         0, 1, 32'h1,         1, 8'h62};
        tbl[26] = '{0, CON,     32'h0,         0, 1, 32'h4,         1, 8'h62};
        tbl[27] = '{1, STAT,    32'h4,         0, 1, 32'h1,         1, 8'h62};
        tbl[28] = '{0, STAT,    32'h0,         0, 1, 32'h1,         1, 8'h62};
        tbl[29] = '{1, SCR,     32'hCAFE_F00D, 0, 1, 32'h0,         1, 8'h62};
        tbl[30] = '{0, SCR,     32'h0,         0, 1, 32'hCAFE_F00D, 1, 8'h62};
        tbl[31] = '{1, 32'h8000_0010, 32'h1234, 0, 1, 32'h0,        1, 8'h62};
        tbl[32] = '{0, 32'h8000_0010, 32'h0,    0, 1, 32'h0,        1, 8'h62};
        tbl[33] = '{0, SCR,     32'h0,         0, 1, 32'hCAFE_F00D, 1, 8'h62};

        for (int i = 0; i < 256; i++) ram_v[i] = 1'b0;
        model_reset();

        // Reset state, observed while reset is held.
        rst_n = 1'b0; memwrite = 1'b0; memaddr = STAT; writedata = '0; con_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst.con_valid", {31'b0, con_valid}, 32'h0);
        check("rst.con_data", {24'b0, con_data}, 32'h0);
        check("rst.status", readdata, 32'h2);
        memaddr = SCR; #1;
        check("rst.scratch", readdata, 32'h0);
        memaddr = CON; #1;
        check("rst.occupancy", readdata, 32'h0);
        memaddr = CYC; #1;
        check("rst.cycle", readdata, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 34; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            drive(tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].rdy);
            check_model(tag);
            if (tbl[i].chk) check({tag, ".tbl_rd"}, readdata, tbl[i].exp_rd);
            check({tag, ".tbl_cv"}, {31'b0, con_valid}, {31'b0, tbl[i].exp_cv});
            check({tag, ".tbl_cd"}, {24'b0, con_data}, {24'b0, tbl[i].exp_cd});
            commit();
        end

        // Cycle counter.
        step("cyc.wr", 1'b1, CYC, 32'h1234_5678, 1'b0);
        for (int k = 0; k < 5; k++) step("cyc.idle", 1'b0, 32'h0, 32'h0, 1'b0);
        drive(1'b0, CYC, 32'h0, 1'b0);
`ifdef MIPS_DMEM_CYCLE_CNT_EN
        check("cyc.count5", readdata, 32'h5);
`else
        check("cyc.absent", readdata, 32'h0);
`endif
        check_model("cyc.rd");
        commit();

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            pick = $urandom_range(0, 5);
            a    = $urandom;
            wd   = $urandom;
            if (pick < 2) begin
                a[31] = 1'b0;
                a[9:2] = 8'($urandom_range(0, 15));
            end else if (pick < 5) begin
                a = CON | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            end else begin
                a[31] = 1'b1;
                a[4]  = 1'b1;
            end
            step("rand", 1'($urandom_range(0, 1)), a, wd, $urandom_range(0, 2) == 0);
        end

        // Reset mid-operation with three bytes queued.
        for (int k = 0; k < 6; k++) step("drain", 1'b0, 32'h0, 32'h0, 1'b1);
        step("q1", 1'b1, CON, 32'hA1, 1'b0);
        step("q2", 1'b1, CON, 32'hA2, 1'b0);
        step("q3", 1'b1, CON, 32'hA3, 1'b0);
        step("scr", 1'b1, SCR, 32'h5A5A_0001, 1'b0);
        drive(1'b0, SCR, 32'h0, 1'b0);
        check("mid.pre_valid", {31'b0, con_valid}, 32'h1);
        check("mid.pre_data", {24'b0, con_data}, 32'hA1);
        check("mid.pre_scr", readdata, 32'h5A5A_0001);
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        check("mid.con_valid", {31'b0, con_valid}, 32'h0);
        check("mid.con_data", {24'b0, con_data}, 32'h0);
        check("mid.scratch", readdata, 32'h0);
        memaddr = STAT; #1;
        check("mid.status", readdata, 32'h2);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step("post.occ", 1'b0, CON, 32'h0, 1'b1);
        step("post.ram", 1'b0, 32'h10, 32'h0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
